mult_div_sequencer: RTL and testbench

//  Multicycle sequencer for MIPS mult/multu/div/divu; owns the HI/LO register pair.

---
 rtl/mult_div_sequencer.sv | 102 ++++++++++
 tb/tb_mult_div_sequencer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer: multicycle MIPS mult/multu/div/divu engine owning the HI/LO pair
module mult_div_sequencer #(
  parameter int DATA_WIDTH       = 32,
  parameter int ALUControl_width = 5
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        Start,
  input  logic [ALUControl_width-1:0] ALUControl,
  input  logic [DATA_WIDTH-1:0]       SrcA,
  input  logic [DATA_WIDTH-1:0]       SrcB,
  input  logic                        HiWrite,
  input  logic                        LoWrite,
  input  logic [DATA_WIDTH-1:0]       WD,
  output logic                        Busy,
  output logic                        Done,
  output logic                        DivByZero,
  output logic [DATA_WIDTH-1:0]       HI,
  output logic [DATA_WIDTH-1:0]       LO
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
  state_t state, next;
  logic [W-1:0]   a_r, b_r, wh, wl, a_abs, b_abs, q_fix, r_fix, fix_hi, fix_lo;
  logic [CW-1:0]  cnt;
  logic           div_r, neg_q, neg_r;
  logic           is_mul, is_div, op_signed, accept, div_zero;
  logic [W:0]     ms, sh, dt;
  logic [2*W-1:0] prod_fix;
  // decode, accept, next-state and combinational datapath helpers
  always_comb begin
    is_mul    = ALUControl == ALUControl_width'(9) || ALUControl == ALUControl_width'(12);
    is_div    = ALUControl == ALUControl_width'(10) || ALUControl == ALUControl_width'(13);
    op_signed = ALUControl == ALUControl_width'(9) || ALUControl == ALUControl_width'(10);
    accept    = state == IDLE && Start && (is_mul || is_div);
    div_zero  = is_div && SrcB == '0;
    a_abs     = op_signed && SrcA[W-1] ? -SrcA : SrcA;
    b_abs     = op_signed && SrcB[W-1] ? -SrcB : SrcB;
    ms        = {1'b0, wh} + (wl[0] ? {1'b0, a_r} : '0);
    sh        = {wh, wl[W-1]};
    dt        = sh - {1'b0, b_r};
    prod_fix  = neg_q ? -{wh, wl} : {wh, wl};
    q_fix     = neg_q ? -wl : wl;
    r_fix     = neg_r ? -wh : wh;
    fix_hi    = div_r ? r_fix : prod_fix[2*W-1:W];
    fix_lo    = div_r ? q_fix : prod_fix[W-1:0];
    next      = state;
    case (state)
      IDLE:    next = accept ? (div_zero ? DONE : is_div ? DIV : MUL) : IDLE;
      MUL,
      DIV:     next = cnt == CW'(1) ? FIX : state;
      FIX:     next = DONE;
      default: next = IDLE;
    endcase
    Busy = state != IDLE;
  end
  // state register
  always_ff @(posedge CLK or negedge RST)
    if (!RST) state <= IDLE;
    else state <= next;
  // operand latch, iteration, result write-back and status pulses
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      {a_r, b_r, wh, wl, cnt, div_r, neg_q, neg_r} <= '0;
      {HI, LO, Done, DivByZero} <= '0;
    end else begin
      Done      <= next == DONE;
      DivByZero <= accept && div_zero;
      if (state == IDLE && HiWrite) HI <= WD;
      if (state == IDLE && LoWrite) LO <= WD;
      if (accept) begin
        a_r   <= a_abs;
        b_r   <= b_abs;
        wh    <= '0;
        wl    <= is_div ? a_abs : b_abs;
        cnt   <= CW'(W);
        div_r <= is_div;
        neg_q <= op_signed && (SrcA[W-1] ^ SrcB[W-1]);
        neg_r <= op_signed && SrcA[W-1];
        if (div_zero) begin
          HI <= SrcA;
          LO <= '1;
        end
      end
      if (state == MUL) begin
        wh  <= ms[W:1];
        wl  <= {ms[0], wl[W-1:1]};
        cnt <= cnt - CW'(1);
      end
      if (state == DIV) begin
        wh  <= dt[W] ? sh[W-1:0] : dt[W-1:0];
        wl  <= {wl[W-2:0], ~dt[W]};
        cnt <= cnt - CW'(1);
      end
      if (state == FIX) begin
        HI <= fix_hi;
        LO <= fix_lo;
      end
    end
  end
endmodule

// File: tb/tb_mult_div_sequencer.sv
// tb_mult_div_sequencer: directed checks of the mult/div sequencer
module tb_mult_div_sequencer;
  logic        CLK = 0, RST = 0, Start = 0, HiWrite = 0, LoWrite = 0;
  logic [4:0]  ALUControl = 0;
  logic [31:0] SrcA = 0, SrcB = 0, WD = 0, HI, LO;
  logic        Busy, Done, DivByZero;
  int checks = 0, failures = 0;

  mult_div_sequencer dut (
    .CLK(CLK), .RST(RST), .Start(Start), .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB),
    .HiWrite(HiWrite), .LoWrite(LoWrite), .WD(WD), .Busy(Busy), .Done(Done),
    .DivByZero(DivByZero), .HI(HI), .LO(LO)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // launch an op in an IDLE cycle, scramble operands afterwards, wait for Done
  task automatic do_op(input string tag, input logic [4:0] code, input logic [31:0] a, b,
                       input logic [31:0] ehi, elo, input int elat, input logic edz);
    int lat;
    @(negedge CLK);
    Start = 1; ALUControl = code; SrcA = a; SrcB = b;
    @(negedge CLK);
    Start = 0; SrcA = ~a; SrcB = b + 32'd3;
    lat = 1;
    chk({tag, "_busy"}, Busy, 1);
    while (!Done && lat < 100) begin
      @(negedge CLK);
      lat++;
    end
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_hi"}, HI, ehi);
    chk({tag, "_lo"}, LO, elo);
    chk({tag, "_dz"}, DivByZero, edz);
  endtask

  initial begin
    int lat, dones;
    #12;
    chk("rst_hi", HI, 0);
    chk("rst_lo", LO, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", {Done, DivByZero}, 0);
    @(negedge CLK);
    RST = 1;
    do_op("multu_max", 12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34, 0);
    do_op("mult_m7x3", 9, 32'hFFFFFFF9, 3, 32'hFFFFFFFF, 32'hFFFFFFEB, 34, 0);
    do_op("mult_m1xm1", 9, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1, 34, 0);
    do_op("multu_shift", 12, 32'h12345678, 32'h10, 1, 32'h23456780, 34, 0);
    do_op("div_m7d2", 10, 32'hFFFFFFF9, 2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34, 0);
    do_op("div_7dm2", 10, 7, 32'hFFFFFFFE, 1, 32'hFFFFFFFD, 34, 0);
    do_op("divu_100d7", 13, 100, 7, 2, 14, 34, 0);
    do_op("div_ovf", 10, 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 34, 0);
    do_op("divu_by0", 13, 5, 0, 5, 32'hFFFFFFFF, 1, 1);
    do_op("div_by0", 10, 32'hFFFFFFF0, 0, 32'hFFFFFFF0, 32'hFFFFFFFF, 1, 1);
    @(negedge CLK);
    chk("idle_after_done", Busy, 0);
    chk("dz_pulse", DivByZero, 0);
    // Start and HiWrite while busy must be ignored
    Start = 1; ALUControl = 12; SrcA = 6; SrcB = 7;
    @(negedge CLK);
    Start = 0;
    repeat (5) @(negedge CLK);
    Start = 1; ALUControl = 13; SrcA = 9; SrcB = 0; HiWrite = 1; WD = 32'hAA;
    @(negedge CLK);
    Start = 0; HiWrite = 0;
    chk("busy_hi_hold", HI, 32'hFFFFFFF0);
    lat = 0;
    while (!Done && lat < 100) begin
      @(negedge CLK);
      lat++;
    end
    chk("busy_ign_hi", HI, 0);
    chk("busy_ign_lo", LO, 42);
    @(negedge CLK);
    chk("no_requeue", Busy, 0);
    HiWrite = 1; WD = 32'hAA;
    @(negedge CLK);
    HiWrite = 0;
    chk("mthi", HI, 32'hAA);
    chk("mthi_lo", LO, 42);
    LoWrite = 1; WD = 32'h55;
    @(negedge CLK);
    LoWrite = 0;
    chk("mtlo", LO, 32'h55);
    // unsupported op code is never accepted
    Start = 1; ALUControl = 0; SrcA = 1; SrcB = 1;
    repeat (2) @(negedge CLK);
    chk("add_no_busy", Busy, 0);
    Start = 0;
    // reset in the middle of a multiply
    Start = 1; ALUControl = 9; SrcA = 32'h1234; SrcB = 32'h5678;
    @(negedge CLK);
    Start = 0;
    repeat (10) @(negedge CLK);
    RST = 0;
    #1;
    chk("mid_rst_hi", HI, 0);
    chk("mid_rst_lo", LO, 0);
    chk("mid_rst_busy", Busy, 0);
    @(negedge CLK);
    RST = 1;
    dones = 0;
    repeat (40) begin
      @(negedge CLK);
      dones += int'(Done);
    end
    chk("mid_rst_nodone", dones, 0);
    chk("mid_rst_idle", Busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
